// File: rtl/fib_capture_pkg.sv
// rtl/fib_capture_pkg.sv - register map and field positions for fib_capture
// Purpose: shared register offsets, CTRL/STATUS bit indices and WRAPCNT width.
// Ports: none (package).
package fib_capture_pkg;

  // Register index taken from wbs_adr_i[3:2]
  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_DATA    = 2'd2;
  localparam logic [1:0] REG_WRAPCNT = 2'd3;

  // CTRL bits
  localparam int CTRL_ARM    = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_CLEAR  = 2;

  // STATUS bits; count occupies [7:0]
  localparam int STAT_FULL  = 8;
  localparam int STAT_EMPTY = 9;
  localparam int STAT_WRAP  = 10;

  localparam int WRAPCNT_W = 16;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with flush, count, full and empty
// Purpose: DEPTH-entry FIFO, head presented combinationally (0 when empty).
// Ports:
//   clk, reset_n        clock, async active-low reset
//   flush_i             empty the FIFO (wins over push/pop)
//   push_i, push_data_i write request and data (ignored when full)
//   pop_i               read request (ignored when empty)
//   head_o              oldest entry, 0 when empty
//   count_o             occupancy 0..DEPTH
//   full_o, empty_o     status flags
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  // Extra MSB on each pointer distinguishes full from empty when indices match
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push, do_pop;

  always_comb begin
    empty_o  = (wr_ptr_q == rd_ptr_q);
    full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    count_o  = wr_ptr_q - rd_ptr_q;
    do_push  = push_i & ~full_o & ~flush_i;
    do_pop   = pop_i & ~empty_o & ~flush_i;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end
    head_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: head_o is masked while empty
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/fib_capture.sv
// rtl/fib_capture.sv - fibonacci term capture FIFO, wrap detector and Wishbone slave
// Purpose: captures `value` while armed, flags unsigned wrap-around, raises irq,
//          exposes CTRL/STATUS/DATA/WRAPCNT over a Wishbone classic slave.
// Ports:
//   clk, reset_n          clock, async active-low reset
//   value                 fibonacci term, one per clock
//   wbs_stb_i/cyc_i/we_i  Wishbone strobe, cycle, write enable
//   wbs_sel_i             byte selects (only byte 0 matters on writes)
//   wbs_adr_i, wbs_dat_i  address and write data
//   wbs_ack_o, wbs_dat_o  acknowledge and read data (0 outside ack)
//   irq                   registered WRAP & IRQ_EN
module fib_capture
  import fib_capture_pkg::*;
#(
  parameter int          WIDTH     = 32,
  parameter int          DEPTH     = 8,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] value,
  input  logic             wbs_stb_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_adr_i,
  input  logic [31:0]      wbs_dat_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  output logic             irq
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic                 ack_q, ack_d;
  logic                 arm_q, arm_d;
  logic                 irq_en_q, irq_en_d;
  logic                 wrap_q, wrap_d;
  logic                 irq_q, irq_d;
  logic                 prev_valid_q, prev_valid_d;
  logic [WIDTH-1:0]     prev_q, prev_d;
  logic [WRAPCNT_W-1:0] wrapcnt_q, wrapcnt_d;

  logic             req, hit, access, ctrl_wr, clear, fifo_pop, wrap_event;
  logic [1:0]       reg_sel;
  logic [31:0]      rdata;
  logic [WIDTH-1:0] fifo_head;
  logic [CW-1:0]    fifo_count;
  logic             fifo_full, fifo_empty;
  logic             unused_bits;

  assign unused_bits = ^{wbs_sel_i[3:1], wbs_adr_i[1:0], wbs_dat_i[31:3]};

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush_i     (clear),
    .push_i      (arm_q),
    .push_data_i (value),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  always_comb begin
    req     = wbs_stb_i & wbs_cyc_i;
    // Ack follows a fresh request by one cycle; the ~ack_q term forbids back-to-back acks
    ack_d   = req & ~ack_q;
    hit     = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    reg_sel = wbs_adr_i[3:2];
    // Side effects land on the ack cycle while the master still holds the request
    access   = ack_q & req & hit;
    ctrl_wr  = access & wbs_we_i & wbs_sel_i[0] & (reg_sel == REG_CTRL);
    clear    = ctrl_wr & wbs_dat_i[CTRL_CLEAR];
    fifo_pop = access & ~wbs_we_i & (reg_sel == REG_DATA);

    wrap_event = prev_valid_q & (value < prev_q);

    arm_d        = ctrl_wr ? wbs_dat_i[CTRL_ARM]    : arm_q;
    irq_en_d     = ctrl_wr ? wbs_dat_i[CTRL_IRQ_EN] : irq_en_q;
    prev_d       = value;
    prev_valid_d = ~clear;
    wrap_d       = wrap_q | wrap_event;
    wrapcnt_d    = wrapcnt_q;
    if (wrap_event && (wrapcnt_q != {WRAPCNT_W{1'b1}})) wrapcnt_d = wrapcnt_q + 1'b1;
    if (clear) begin
      wrap_d    = 1'b0;
      wrapcnt_d = '0;
    end
    irq_d = wrap_q & irq_en_q;

    rdata = '0;
    if (hit) begin
      case (reg_sel)
        REG_CTRL: begin
          rdata[CTRL_ARM]    = arm_q;
          rdata[CTRL_IRQ_EN] = irq_en_q;
        end
        REG_STATUS: begin
          rdata[7:0]        = 8'(fifo_count);
          rdata[STAT_FULL]  = fifo_full;
          rdata[STAT_EMPTY] = fifo_empty;
          rdata[STAT_WRAP]  = wrap_q;
        end
        REG_DATA:    rdata = 32'(fifo_head);
        default:     rdata = 32'(wrapcnt_q);
      endcase
    end
    wbs_dat_o = ack_q ? rdata : '0;
    wbs_ack_o = ack_q;
    irq       = irq_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_q        <= 1'b0;
      arm_q        <= 1'b0;
      irq_en_q     <= 1'b0;
      wrap_q       <= 1'b0;
      irq_q        <= 1'b0;
      prev_valid_q <= 1'b0;
      prev_q       <= '0;
      wrapcnt_q    <= '0;
    end else begin
      ack_q        <= ack_d;
      arm_q        <= arm_d;
      irq_en_q     <= irq_en_d;
      wrap_q       <= wrap_d;
      irq_q        <= irq_d;
      prev_valid_q <= prev_valid_d;
      prev_q       <= prev_d;
      wrapcnt_q    <= wrapcnt_d;
    end
  end

endmodule

// File: tb/tb_fib_capture.sv
// tb/tb_fib_capture.sv - directed self-checking bench for fib_capture
module tb_fib_capture;

  localparam logic [31:0] A_CTRL    = 32'h3000_0000;
  localparam logic [31:0] A_STATUS  = 32'h3000_0004;
  localparam logic [31:0] A_DATA    = 32'h3000_0008;
  localparam logic [31:0] A_WRAPCNT = 32'h3000_000C;
  localparam logic [31:0] A_OTHER   = 32'h3000_0040;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] value;
  logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        irq;

  int          checks   = 0;
  int          failures = 0;
  bit          auto_inc = 1'b0;
  logic [31:0] rd;
  logic [31:0] cur;
  logic [31:0] fib_exp [8] = '{32'd0, 32'd1, 32'd1, 32'd2, 32'd3, 32'd5, 32'd8, 32'd13};
  logic [31:0] feed    [10] = '{32'd0, 32'd1, 32'd1, 32'd2, 32'd3, 32'd5, 32'd8, 32'd13, 32'd21, 32'd34};

  fib_capture dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .value     (value),
    .wbs_stb_i (wbs_stb_i),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_sel_i (wbs_sel_i),
    .wbs_adr_i (wbs_adr_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_ack_o (wbs_ack_o),
    .wbs_dat_o (wbs_dat_o),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
    if (auto_inc) value = value + 32'd1;
  endtask

  task automatic wb_access(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           output logic [31:0] rdat);
    int n;
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr;  wbs_dat_i = dat;  wbs_sel_i = 4'hF;
    n = 0;
    tick;
    while (!wbs_ack_o && n < 4) begin
      tick;
      n++;
    end
    checks++;
    if (wbs_ack_o !== 1'b1) begin
      failures++;
      $display("FAIL wb_ack adr=%h got=%b exp=1", adr, wbs_ack_o);
    end
    rdat = wbs_dat_o;
    tick;
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat);
    logic [31:0] dummy;
    wb_access(1'b1, adr, dat, dummy);
  endtask

  task automatic wb_read(input logic [31:0] adr, output logic [31:0] rdat);
    wb_access(1'b0, adr, 32'h0, rdat);
  endtask

  task automatic test_reset;
    logic [31:0] adrs [5] = '{A_CTRL, A_STATUS, A_DATA, A_WRAPCNT, A_OTHER};
    logic [31:0] exps [5] = '{32'h0, 32'h200, 32'h0, 32'h0, 32'h0};
    reset_n = 1'b0; value = '0;
    wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0; wbs_sel_i = 0; wbs_adr_i = 0; wbs_dat_i = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({wbs_ack_o, irq, wbs_dat_o} !== 34'h0) begin
      failures++;
      $display("FAIL reset_outputs got ack=%b irq=%b dat=%h exp all 0", wbs_ack_o, irq, wbs_dat_o);
    end
    reset_n = 1'b1;
    tick;
    for (int i = 0; i < 5; i++) begin
      wb_read(adrs[i], rd);
      checks++;
      if (rd !== exps[i]) begin
        failures++;
        $display("FAIL reset_reg%0d got=%h exp=%h", i, rd, exps[i]);
      end
    end
  endtask

  task automatic test_capture;
    wb_write(A_CTRL, 32'h1);
    for (int i = 0; i < 10; i++) begin
      value = feed[i];
      tick;
    end
    wb_write(A_CTRL, 32'h0);
    wb_read(A_STATUS, rd);
    checks++;
    if (rd !== 32'h108) begin failures++; $display("FAIL capture_full_status got=%h exp=%h", rd, 32'h108); end
    for (int i = 0; i < 8; i++) begin
      wb_read(A_DATA, rd);
      checks++;
      if (rd !== fib_exp[i]) begin failures++; $display("FAIL capture_data%0d got=%h exp=%h", i, rd, fib_exp[i]); end
    end
    wb_read(A_DATA, rd);
    checks++;
    if (rd !== 32'h0) begin failures++; $display("FAIL capture_empty_read got=%h exp=0", rd); end
    wb_read(A_STATUS, rd);
    checks++;
    if (rd !== 32'h200) begin failures++; $display("FAIL capture_drained_status got=%h exp=%h", rd, 32'h200); end
    wb_read(A_WRAPCNT, rd);
    checks++;
    if (rd !== 32'h0) begin failures++; $display("FAIL equal_terms_no_wrap got=%h exp=0", rd); end
  endtask

  task automatic test_wrap;
    logic [31:0] seq [3] = '{32'd1134903170, 32'd1836311903, 32'd2971215073};
    wb_write(A_CTRL, 32'h2);
    for (int i = 0; i < 3; i++) begin
      value = seq[i];
      tick;
    end
    value = 32'd512559680;
    tick;
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL irq_early got=%b exp=0", irq); end
    tick;
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL irq_raise got=%b exp=1", irq); end
    wb_read(A_STATUS, rd);
    checks++;
    if (rd !== 32'h600) begin failures++; $display("FAIL wrap_status got=%h exp=%h", rd, 32'h600); end
    wb_read(A_WRAPCNT, rd);
    checks++;
    if (rd !== 32'h1) begin failures++; $display("FAIL wrapcnt_one got=%h exp=1", rd); end
    wb_write(A_CTRL, 32'h6);
    tick;
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL irq_after_clear got=%b exp=0", irq); end
    wb_read(A_WRAPCNT, rd);
    checks++;
    if (rd !== 32'h0) begin failures++; $display("FAIL wrapcnt_clear got=%h exp=0", rd); end
    wb_read(A_CTRL, rd);
    checks++;
    if (rd !== 32'h2) begin failures++; $display("FAIL ctrl_readback got=%h exp=2", rd); end
  endtask

  task automatic test_clear_wins;
    value = 32'd3000000000;
    tick;
    tick;
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b1;
    wbs_adr_i = A_CTRL; wbs_dat_i = 32'h6; wbs_sel_i = 4'h1;
    tick;
    value = 32'd5;
    tick;
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
    tick;
    wb_read(A_STATUS, rd);
    checks++;
    if (rd !== 32'h200) begin failures++; $display("FAIL clear_wins_status got=%h exp=%h", rd, 32'h200); end
    wb_read(A_WRAPCNT, rd);
    checks++;
    if (rd !== 32'h0) begin failures++; $display("FAIL clear_wins_wrapcnt got=%h exp=0", rd); end
  endtask

  task automatic test_back_to_back;
    value = 32'd100;
    auto_inc = 1'b1;
    wb_write(A_CTRL, 32'h1);
    tick;
    tick;
    wb_read(A_DATA, rd);
    checks++;
    if (rd !== 32'd102) begin failures++; $display("FAIL pushpop_head got=%0d exp=102", rd); end
    wb_write(A_CTRL, 32'h0);
    auto_inc = 1'b0;
    wb_read(A_STATUS, rd);
    checks++;
    if (rd !== 32'h005) begin failures++; $display("FAIL pushpop_count got=%h exp=%h", rd, 32'h005); end
    for (int i = 0; i < 5; i++) begin
      wb_read(A_DATA, rd);
      checks++;
      if (rd !== 32'd103 + 32'(i)) begin failures++; $display("FAIL pushpop_order%0d got=%0d exp=%0d", i, rd, 103 + i); end
    end
  endtask

  task automatic test_reset_mid;
    wb_write(A_CTRL, 32'h3);
    value = 32'd50;
    tick;
    tick;
    tick;
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = A_STATUS;
    #2;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({wbs_ack_o, irq, wbs_dat_o} !== 34'h0) begin
      failures++;
      $display("FAIL reset_mid_outputs got ack=%b irq=%b dat=%h exp all 0", wbs_ack_o, irq, wbs_dat_o);
    end
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
    tick;
    reset_n = 1'b1;
    tick;
    wb_read(A_CTRL, rd);
    checks++;
    if (rd !== 32'h0) begin failures++; $display("FAIL reset_mid_ctrl got=%h exp=0", rd); end
    wb_read(A_STATUS, rd);
    checks++;
    if (rd !== 32'h200) begin failures++; $display("FAIL reset_mid_status got=%h exp=%h", rd, 32'h200); end
    wb_read(A_WRAPCNT, rd);
    checks++;
    if (rd !== 32'h0) begin failures++; $display("FAIL reset_mid_wrapcnt got=%h exp=0", rd); end
  endtask

  task automatic test_saturate;
    logic [31:0] exps [4] = '{32'd1000, 32'hFFFE, 32'hFFFF, 32'hFFFF};
    int          steps [4] = '{1000, 64534, 1, 5};
    wb_write(A_CTRL, 32'h4);
    cur = 32'hFFFF_FFFF;
    value = cur;
    tick;
    for (int s = 0; s < 4; s++) begin
      repeat (steps[s]) begin
        cur = cur - 32'd1;
        value = cur;
        tick;
      end
      wb_read(A_WRAPCNT, rd);
      checks++;
      if (rd !== exps[s]) begin failures++; $display("FAIL wrapcnt_sat%0d got=%h exp=%h", s, rd, exps[s]); end
    end
  endtask

  initial begin
    test_reset;
    test_capture;
    test_wrap;
    test_clear_wins;
    test_back_to_back;
    test_reset_mid;
    test_saturate;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
